// File: rtl/edge_pattern_gen_if.sv
// Bundles the edge_pattern_gen request fields and its status outputs.
// master = the side that requests trains, slave = the generator itself.
interface edge_pattern_gen_if #(
  parameter int unsigned CNT_W = 8
);

  logic             start_i;
  logic [CNT_W-1:0] high_len_i;
  logic [CNT_W-1:0] low_len_i;
  logic [CNT_W-1:0] num_pulses_i;
  logic             abort_i;
  logic             a_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] pulses_done_o;

  modport master (
    output start_i, high_len_i, low_len_i, num_pulses_i, abort_i,
    input  a_o, busy_o, done_o, pulses_done_o
  );

  modport slave (
    input  start_i, high_len_i, low_len_i, num_pulses_i, abort_i,
    output a_o, busy_o, done_o, pulses_done_o
  );

endinterface

// File: rtl/edge_pattern_gen.sv
// Programmable pulse-train generator: N pulses of H high / L low cycles on a
// registered level output, followed by a one-cycle done strobe.
module edge_pattern_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  edge_pattern_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Train parameters captured when a start is accepted
  typedef struct packed {
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num;
  } cfg_t;

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] phase_q, phase_d;  // cycles left in the current phase, minus one
  logic [CNT_W-1:0] cnt_q, cnt_d;      // completed pulses
  logic             a_q, a_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state, counter and output decode
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Abort together with start drops the start
        if (bus.start_i && !bus.abort_i) begin
          cfg_d.high_len = (bus.high_len_i == '0) ? ONE : bus.high_len_i;
          cfg_d.low_len  = (bus.low_len_i  == '0) ? ONE : bus.low_len_i;
          cfg_d.num      = bus.num_pulses_i;
          cnt_d          = '0;
          if (bus.num_pulses_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = HIGH;
            phase_d = cfg_d.high_len - ONE;
          end
        end
      end

      HIGH: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (phase_q == '0) begin
          state_d = LOW;
          phase_d = cfg_q.low_len - ONE;
        end else begin
          phase_d = phase_q - ONE;
        end
      end

      LOW: begin
        // Abort has priority, even on the final low cycle of a pulse
        if (bus.abort_i) begin
          state_d = IDLE;
        end else if (phase_q == '0) begin
          cnt_d = cnt_q + ONE;
          if (cnt_d == cfg_q.num) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            phase_d = cfg_q.high_len - ONE;
          end
        end else begin
          phase_d = phase_q - ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    a_d    = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs; reset drops a_o immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a_o           = a_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.pulses_done_o = cnt_q;

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Bench for edge_pattern_gen: directed scenarios plus random trains, checked
// every cycle against a schedule model (elapsed time since start, div/mod).
module tb_edge_pattern_gen;

  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic reset;

  edge_pattern_gen_if #(.CNT_W(CNT_W)) bus ();

  edge_pattern_gen #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a running train is described by its elapsed cycle count
  int m_run, m_t, m_h, m_l, m_n, m_pulses, m_done;

  // Edge counters on sampled a_o
  logic prev_a = 1'b0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_h = 0; m_l = 0; m_n = 0; m_pulses = 0; m_done = 0;
  endtask

  // Advance the model over one rising edge with the inputs sampled there
  task automatic model_edge(input logic s, input logic ab, input int h, input int l, input int n);
    int p;
    m_done = 0;
    if (m_run != 0) begin
      p = m_h + m_l;
      if (ab) begin
        m_run    = 0;
        m_pulses = m_t / p;
      end else begin
        m_t++;
        if (m_t == m_n * p) begin
          m_run    = 0;
          m_done   = 1;
          m_pulses = m_n;
        end else begin
          m_pulses = m_t / p;
        end
      end
    end else if (s && !ab) begin
      m_h      = (h == 0) ? 1 : h;
      m_l      = (l == 0) ? 1 : l;
      m_n      = n;
      m_pulses = 0;
      if (n == 0) m_done = 1;
      else begin
        m_run = 1;
        m_t   = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    logic exp_a;
    exp_a = 1'b0;
    if (m_run != 0) exp_a = ((m_t % (m_h + m_l)) < m_h);
    check_eq("a_o",           32'(bus.a_o),           32'(exp_a));
    check_eq("busy_o",        32'(bus.busy_o),        32'(m_run != 0));
    check_eq("done_o",        32'(bus.done_o),        32'(m_done));
    check_eq("pulses_done_o", 32'(bus.pulses_done_o), 32'(m_pulses));
    if (bus.a_o && !prev_a) rise_cnt++;
    if (!bus.a_o && prev_a) fall_cnt++;
    prev_a = bus.a_o;
  endtask

  // One clock: drive inputs, model the edge, sample on the falling edge
  task automatic step(input logic s, input logic ab, input int h, input int l, input int n);
    bus.start_i      = s;
    bus.abort_i      = ab;
    bus.high_len_i   = CNT_W'(h);
    bus.low_len_i    = CNT_W'(l);
    bus.num_pulses_i = CNT_W'(n);
    @(posedge clk);
    model_edge(s, ab, h, l, n);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_steps(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  logic [12:0] pat13;
  logic [3:0]  pat4;
  int          high_cnt;
  int          done_seen;

  initial begin
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    bus.high_len_i = '0; bus.low_len_i = '0; bus.num_pulses_i = '0;
    model_reset();

    // Reset held for three cycles
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_eq("rst_a",     32'(bus.a_o), 0);
    check_eq("rst_busy",  32'(bus.busy_o), 0);
    check_eq("rst_done",  32'(bus.done_o), 0);
    check_eq("rst_count", 32'(bus.pulses_done_o), 0);
    idle_steps(2);

    // Basic train H=3 L=2 N=4
    rise_cnt = 0; fall_cnt = 0;
    step(1'b1, 1'b0, 3, 2, 4);
    for (int i = 1; i < 20; i++) step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0);
    check_eq("basic_done",  32'(bus.done_o), 1);
    check_eq("basic_count", 32'(bus.pulses_done_o), 4);
    check_eq("basic_rises", 32'(rise_cnt), 4);
    check_eq("basic_falls", 32'(fall_cnt), 4);
    idle_steps(2);

    // Zero lengths behave as one
    pat4 = '0;
    step(1'b1, 1'b0, 0, 0, 2);
    pat4 = {pat4[2:0], bus.a_o};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      pat4 = {pat4[2:0], bus.a_o};
    end
    check_eq("zero_len_pattern", 32'(pat4), 32'(4'b1010));
    step(1'b0, 1'b0, 0, 0, 0);
    check_eq("zero_len_done", 32'(bus.done_o), 1);
    idle_steps(2);

    // N=0: immediate done, never busy
    step(1'b1, 1'b0, 5, 5, 0);
    check_eq("n0_done", 32'(bus.done_o), 1);
    check_eq("n0_busy", 32'(bus.busy_o), 0);
    idle_steps(2);

    // Maximum high length
    high_cnt = 0;
    step(1'b1, 1'b0, 255, 1, 1);
    if (bus.a_o) high_cnt++;
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b0, 0, 0, 0);
      if (bus.a_o) high_cnt++;
    end
    check_eq("max_high_cycles", 32'(high_cnt), 255);
    check_eq("max_count", 32'(bus.pulses_done_o), 1);
    idle_steps(2);

    // Abort in the second cycle of the third high phase
    done_seen = 0;
    step(1'b1, 1'b0, 2, 2, 5);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 0, 0, 0);
    check_eq("abort_a",     32'(bus.a_o), 0);
    check_eq("abort_busy",  32'(bus.busy_o), 0);
    check_eq("abort_count", 32'(bus.pulses_done_o), 2);
    for (int i = 0; i < 5; i++) begin
      if (bus.done_o) done_seen++;
      step(1'b0, 1'b0, 0, 0, 0);
    end
    if (bus.done_o) done_seen++;
    check_eq("abort_no_done", 32'(done_seen), 0);

    // Abort together with start in idle drops the start
    step(1'b1, 1'b1, 3, 2, 4);
    check_eq("abort_start_busy", 32'(bus.busy_o), 0);
    check_eq("abort_start_done", 32'(bus.done_o), 0);
    idle_steps(2);

    // Start held through a train; fields scrambled while busy
    pat13 = '0;
    step(1'b1, 1'b0, 1, 1, 3);
    pat13 = {pat13[11:0], bus.a_o};
    for (int i = 0; i < 12; i++) begin
      if (m_run != 0) step(1'b1, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      else            step(1'b1, 1'b0, 1, 1, 3);
      pat13 = {pat13[11:0], bus.a_o};
    end
    check_eq("b2b_pattern", 32'(pat13), 32'(13'b1010100101010));
    idle_steps(6);

    // Asynchronous reset in the middle of a high phase
    step(1'b1, 1'b0, 5, 1, 2);
    step(1'b0, 1'b0, 0, 0, 0);
    check_eq("pre_rst_a", 32'(bus.a_o), 1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_a",    32'(bus.a_o), 0);
    check_eq("async_rst_busy", 32'(bus.busy_o), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    prev_a = 1'b0;
    idle_steps(2);

    // Random trains with start/abort noise and scrambled fields
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      for (int c = 0; c < 110; c++) begin
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
